// File: rtl/mips_store_unit.sv
// -----------------------------------------------------------------------------
// mips_store_unit
//
// Store path of the 32-bit MIPS datapath. Accepts SB/SH/SW requests from the
// MEM stage and writes them to a word-wide data memory without byte enables.
// Word stores are written directly; byte and halfword stores truncate the
// register value and merge it into the addressed word by read-modify-write.
// Byte order is big-endian (offset 0 is bits [31:24]).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   st_valid   in   store request, sampled while st_ready = 1
//   st_ready   out  unit idle; request accepted on st_valid && st_ready
//   st_size    in   00 byte, 01 half, 10 word, 11 illegal
//   st_addr    in   byte address
//   st_data    in   rt register value
//   mem_addr   out  word address, bits [1:0] always 0
//   mem_re     out  memory read strobe
//   mem_rdata  in   read data, valid the cycle after mem_re
//   mem_we     out  memory write strobe
//   mem_wdata  out  full word to write
//   st_done    out  one-cycle pulse on the cycle the write is issued
//   st_err     out  one-cycle pulse on a rejected request
//
// Configuration macro: STORE_MISALIGN_TRAP_EN
//   defined   : misaligned half/word stores are rejected through st_err.
//   undefined : offending low address bits are ignored and the store proceeds.
//   st_size = 11 is always rejected.
//
// All outputs are registered: each output register is loaded with the value
// belonging to the state the FSM enters at the same edge.
// -----------------------------------------------------------------------------
module mips_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic        st_done,
   output logic        st_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef STORE_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   // Replace one big-endian lane of a word with the narrowed store data.
   function automatic logic [31:0] merge_lane(
      input logic [31:0] word,
      input logic        is_half,
      input logic [1:0]  off,
      input logic [15:0] lane
   );
      logic [31:0] merged;
      merged = word;
      if (is_half) begin
         if (off[1]) begin
            merged[15:0] = lane;
         end else begin
            merged[31:16] = lane;
         end
      end else begin
         case (off)
            2'd0:    merged[31:24] = lane[7:0];
            2'd1:    merged[23:16] = lane[7:0];
            2'd2:    merged[15:8]  = lane[7:0];
            default: merged[7:0]   = lane[7:0];
         endcase
      end
      return merged;
   endfunction

   logic [2:0]  state_r;
   logic [2:0]  state_nx_s;
   logic        half_r;
   logic        half_nx_s;
   logic [1:0]  off_r;
   logic [1:0]  off_nx_s;
   logic [15:0] lane_r;
   logic [15:0] lane_nx_s;

   logic        st_ready_r;
   logic        mem_re_r;
   logic        mem_we_r;
   logic        st_done_r;
   logic        st_err_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;

   logic        mem_re_nx_s;
   logic        mem_we_nx_s;
   logic        st_done_nx_s;
   logic        st_err_nx_s;
   logic [31:0] mem_addr_nx_s;
   logic [31:0] mem_wdata_nx_s;

   logic        illegal_s;
   logic [1:0]  eff_off_s;

   // Classify the incoming request and compute the lane offset actually used.
   always_comb begin
      illegal_s = 1'b0;
      eff_off_s = st_addr[1:0];
      case (st_size)
         SZ_BYTE: begin
            illegal_s = 1'b0;
            eff_off_s = st_addr[1:0];
         end
         SZ_HALF: begin
            // Halfword lane is selected by addr[1] alone; addr[0] is either
            // trapped or ignored.
            illegal_s = TRAP_EN & st_addr[0];
            eff_off_s = {st_addr[1], 1'b0};
         end
         SZ_WORD: begin
            illegal_s = TRAP_EN & (st_addr[1:0] != 2'b00);
            eff_off_s = 2'b00;
         end
         default: begin
            illegal_s = 1'b1;
            eff_off_s = 2'b00;
         end
      endcase
   end

   // Next-state and next-output logic for the store sequencer.
   always_comb begin
      state_nx_s     = state_r;
      half_nx_s      = half_r;
      off_nx_s       = off_r;
      lane_nx_s      = lane_r;
      mem_re_nx_s    = 1'b0;
      mem_we_nx_s    = 1'b0;
      st_done_nx_s   = 1'b0;
      st_err_nx_s    = 1'b0;
      mem_addr_nx_s  = mem_addr_r;
      mem_wdata_nx_s = mem_wdata_r;
      case (state_r)
         S_IDLE: begin
            if (st_valid) begin
               half_nx_s = (st_size == SZ_HALF);
               off_nx_s  = eff_off_s;
               lane_nx_s = st_data[15:0];
               if (illegal_s) begin
                  state_nx_s  = S_ERR;
                  st_err_nx_s = 1'b1;
               end else if (st_size == SZ_WORD) begin
                  state_nx_s     = S_WRITE;
                  mem_we_nx_s    = 1'b1;
                  st_done_nx_s   = 1'b1;
                  mem_addr_nx_s  = {st_addr[31:2], 2'b00};
                  mem_wdata_nx_s = st_data;
               end else begin
                  state_nx_s    = S_READ;
                  mem_re_nx_s   = 1'b1;
                  mem_addr_nx_s = {st_addr[31:2], 2'b00};
               end
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_READ: begin
            // Read data arrives during MERGE.
            state_nx_s = S_MERGE;
         end
         S_MERGE: begin
            // mem_wdata doubles as the merge register.
            state_nx_s     = S_WRITE;
            mem_we_nx_s    = 1'b1;
            st_done_nx_s   = 1'b1;
            mem_wdata_nx_s = merge_lane(mem_rdata, half_r, off_r, lane_r);
         end
         S_WRITE: begin
            state_nx_s = S_IDLE;
         end
         S_ERR: begin
            state_nx_s = S_IDLE;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // State, latched request and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         half_r      <= 1'b0;
         off_r       <= 2'b00;
         lane_r      <= 16'h0000;
         st_ready_r  <= 1'b1;
         mem_re_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         st_done_r   <= 1'b0;
         st_err_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
      end else begin
         state_r     <= state_nx_s;
         half_r      <= half_nx_s;
         off_r       <= off_nx_s;
         lane_r      <= lane_nx_s;
         st_ready_r  <= (state_nx_s == S_IDLE);
         mem_re_r    <= mem_re_nx_s;
         mem_we_r    <= mem_we_nx_s;
         st_done_r   <= st_done_nx_s;
         st_err_r    <= st_err_nx_s;
         mem_addr_r  <= mem_addr_nx_s;
         mem_wdata_r <= mem_wdata_nx_s;
      end
   end

   assign st_ready  = st_ready_r;
   assign mem_re    = mem_re_r;
   assign mem_we    = mem_we_r;
   assign st_done   = st_done_r;
   assign st_err    = st_err_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule
